wb_sdrc_traffic_gen: RTL and testbench

Synthesizable Wishbone initiator that drives the Wishbone responder port of sdrc_top with incrementing bursts. It writes LFSR-generated data, then reads the same region back and compares it against the regenerated sequence. It replaces the behavioural bench driver for on-silicon and FPGA self-test, and sits between a config/status register block and sdrc_top.

---
 rtl/wb_tg_pkg.sv | 25 ++
 rtl/tg_lfsr32.sv | 28 ++
 rtl/wb_sdrc_traffic_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_wb_sdrc_traffic_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_tg_pkg.sv
// Shared constants for the Wishbone SDRAM traffic generator: FSM encoding,
// cycle-type codes and the LFSR definition.
package wb_tg_pkg;

   localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef logic [2:0] tg_state_t;
   localparam tg_state_t ST_IDLE    = 3'd0;
   localparam tg_state_t ST_WR_BEAT = 3'd1;
   localparam tg_state_t ST_WR_GAP  = 3'd2;
   localparam tg_state_t ST_RD_BEAT = 3'd3;
   localparam tg_state_t ST_RD_GAP  = 3'd4;
   localparam tg_state_t ST_DONE    = 3'd5;

   // One step of the right-shifting Galois LFSR, feedback taken from bit 0.
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
   endfunction

endpackage

// File: rtl/tg_lfsr32.sv
// 32-bit Galois LFSR with synchronous load; advances only when adv is high.
module tg_lfsr32
   import wb_tg_pkg::*;
(
   input  logic        clk,
   input  logic        RESETN,
   input  logic        load,
   input  logic        adv,
   input  logic [31:0] seed,
   output logic [31:0] q
);

   logic [31:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load)     lfsr_d = seed;
      else if (adv) lfsr_d = lfsr_step(lfsr_q);
   end

   always_ff @(posedge clk or negedge RESETN) begin
      if (!RESETN) lfsr_q <= 32'h0;
      else         lfsr_q <= lfsr_d;
   end

   assign q = lfsr_q;

endmodule

// File: rtl/wb_sdrc_traffic_gen.sv
// Wishbone initiator self-test: writes LFSR data in incrementing bursts, reads
// the region back, and reports mismatches, first failing address and ack timeouts.
module wb_sdrc_traffic_gen
   import wb_tg_pkg::*;
#(
   parameter int unsigned aw   = 26,
   parameter int unsigned bl   = 5,
   parameter int unsigned TO_W = 10,
   parameter logic [31:0] SEED = DEFAULT_SEED
) (
   input  logic          sys_clk,
   input  logic          RESETN,
   input  logic          start,
   input  logic [aw-1:0] cfg_base_addr,
   input  logic [bl-1:0] cfg_burst_len,
   input  logic [7:0]    cfg_num_bursts,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic          timeout,
   output logic [15:0]   err_count,
   output logic [aw-1:0] first_err_addr,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic          wb_we_o,
   output logic [aw-1:0] wb_addr_o,
   output logic [31:0]   wb_dat_o,
   output logic [3:0]    wb_sel_o,
   output logic [2:0]    wb_cti_o,
   input  logic          wb_ack_i,
   input  logic [31:0]   wb_dat_i
);

   localparam int unsigned     ERR_W   = 16;
   localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

   tg_state_t      state_q, state_d;
   logic [aw-1:0]  base_q, base_d, addr_q, addr_d, ferr_q, ferr_d;
   logic [bl-1:0]  len_q, len_d, left_q, left_d;
   logic [7:0]     nb_q, nb_d, burst_q, burst_d;
   logic [TO_W-1:0] wd_q, wd_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [2:0]     cti_q, cti_d;
   logic           stb_q, stb_d, we_q, we_d;
   logic           busy_q, busy_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
   logic           lfsr_load, lfsr_adv, ack_v;
   logic [31:0]    lfsr_q;
   logic [bl-1:0]  cfg_len_eff;

   tg_lfsr32 u_lfsr (
      .clk    (sys_clk),
      .RESETN (RESETN),
      .load   (lfsr_load),
      .adv    (lfsr_adv),
      .seed   (SEED),
      .q      (lfsr_q)
   );

   assign ack_v       = wb_ack_i & stb_q;
   assign cfg_len_eff = (cfg_burst_len == '0) ? bl'(1) : cfg_burst_len;

   // left_q counts beats still to go after the current one in this burst.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      addr_d    = addr_q;
      ferr_d    = ferr_q;
      len_d     = len_q;
      left_d    = left_q;
      nb_d      = nb_q;
      burst_d   = burst_q;
      wd_d      = wd_q;
      err_d     = err_q;
      cti_d     = cti_q;
      stb_d     = stb_q;
      we_d      = we_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      tmo_d     = tmo_q;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               base_d    = cfg_base_addr & ~aw'(3);
               addr_d    = cfg_base_addr & ~aw'(3);
               len_d     = cfg_len_eff;
               left_d    = cfg_len_eff - bl'(1);
               nb_d      = (cfg_num_bursts == 8'd0) ? 8'd1 : cfg_num_bursts;
               burst_d   = 8'd0;
               cti_d     = (cfg_len_eff == bl'(1)) ? CTI_EOB : CTI_INCR;
               err_d     = '0;
               ferr_d    = '0;
               tmo_d     = 1'b0;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               busy_d    = 1'b1;
               stb_d     = 1'b1;
               we_d      = 1'b1;
               wd_d      = '0;
               lfsr_load = 1'b1;
               state_d   = ST_WR_BEAT;
            end
         end
         ST_WR_BEAT, ST_RD_BEAT: begin
            if (ack_v) begin
               wd_d     = '0;
               lfsr_adv = 1'b1;
               if (state_q == ST_RD_BEAT && wb_dat_i != lfsr_q) begin
                  if (err_q != '1)      err_d  = err_q + ERR_W'(1);
                  if (err_q == '0)      ferr_d = addr_q;
               end
               if (left_q == '0) begin
                  stb_d   = 1'b0;
                  cti_d   = CTI_CLASSIC;
                  state_d = (state_q == ST_WR_BEAT) ? ST_WR_GAP : ST_RD_GAP;
               end else begin
                  left_d = left_q - bl'(1);
                  addr_d = addr_q + aw'(4);
                  cti_d  = (left_q == bl'(1)) ? CTI_EOB : CTI_INCR;
               end
            end else if (wd_q == WD_LAST) begin
               stb_d   = 1'b0;
               we_d    = 1'b0;
               cti_d   = CTI_CLASSIC;
               tmo_d   = 1'b1;
               done_d  = 1'b1;
               pass_d  = 1'b0;
               busy_d  = 1'b0;
               state_d = ST_DONE;
            end else begin
               wd_d = wd_q + TO_W'(1);
            end
         end
         ST_WR_GAP, ST_RD_GAP: begin
            stb_d  = 1'b1;
            wd_d   = '0;
            left_d = len_q - bl'(1);
            cti_d  = (len_q == bl'(1)) ? CTI_EOB : CTI_INCR;
            if (burst_q == nb_q - 8'd1) begin
               burst_d = 8'd0;
               if (state_q == ST_WR_GAP) begin
                  addr_d    = base_q;
                  we_d      = 1'b0;
                  lfsr_load = 1'b1;
                  state_d   = ST_RD_BEAT;
               end else begin
                  stb_d   = 1'b0;
                  cti_d   = CTI_CLASSIC;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_q == '0);
                  state_d = ST_DONE;
               end
            end else begin
               burst_d = burst_q + 8'd1;
               addr_d  = addr_q + aw'(4);
               state_d = (state_q == ST_WR_GAP) ? ST_WR_BEAT : ST_RD_BEAT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         addr_q  <= '0;
         ferr_q  <= '0;
         len_q   <= '0;
         left_q  <= '0;
         nb_q    <= '0;
         burst_q <= '0;
         wd_q    <= '0;
         err_q   <= '0;
         cti_q   <= CTI_CLASSIC;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         ferr_q  <= ferr_d;
         len_q   <= len_d;
         left_q  <= left_d;
         nb_q    <= nb_d;
         burst_q <= burst_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
         cti_q   <= cti_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         tmo_q   <= tmo_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign timeout        = tmo_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;
   assign wb_cyc_o       = stb_q;
   assign wb_stb_o       = stb_q;
   assign wb_we_o        = we_q;
   assign wb_addr_o      = addr_q;
   assign wb_dat_o       = lfsr_q;
   assign wb_sel_o       = {4{stb_q}};
   assign wb_cti_o       = cti_q;

endmodule

// File: tb/tb_wb_sdrc_traffic_gen.sv
// Self-checking bench: randomized wait-state memory responder plus a
// beat-list reference model built from the address/data/cti rules.
module tb_wb_sdrc_traffic_gen;

   localparam int unsigned AW   = 26;
   localparam logic [31:0] SEED = 32'hACE1_2468;
   localparam logic [31:0] POLY = 32'h8020_0003;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          we;
      logic [31:0]   dat;
      logic [2:0]    cti;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] cfg_base = '0;
   logic [4:0]    cfg_len = '0;
   logic [7:0]    cfg_nb = '0;
   logic          busy, done, pass, timeout;
   logic [15:0]   err_count;
   logic [AW-1:0] first_err_addr;
   logic          cyc, stb, we;
   logic [AW-1:0] addr;
   logic [31:0]   dat_o;
   logic [3:0]    sel;
   logic [2:0]    cti;
   logic          ack = 1'b0;
   logic [31:0]   dat_i = '0;

   logic          rl_load = 1'b0, rl_adv = 1'b0;
   logic [31:0]   rl_q;

   always #5 clk = ~clk;

   wb_sdrc_traffic_gen #(.aw(AW), .bl(5), .TO_W(10), .SEED(SEED)) dut (
      .sys_clk(clk), .RESETN(rst_n), .start(start),
      .cfg_base_addr(cfg_base), .cfg_burst_len(cfg_len), .cfg_num_bursts(cfg_nb),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .err_count(err_count), .first_err_addr(first_err_addr),
      .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_addr_o(addr),
      .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_cti_o(cti),
      .wb_ack_i(ack), .wb_dat_i(dat_i)
   );

   tg_lfsr32 u_ref_lfsr (
      .clk(clk), .RESETN(rst_n), .load(rl_load), .adv(rl_adv), .seed(SEED), .q(rl_q)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference data sequence: value k is SEED stepped k times.
   logic [31:0] exp_lfsr [0:511];
   initial begin
      logic [31:0] v;
      v = SEED;
      for (int k = 0; k < 512; k++) begin
         exp_lfsr[k] = v;
         v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
      end
   end

   // Responder / monitor state.
   int          max_wait = 0;
   bit          no_ack = 1'b0;
   bit          spur = 1'b0;
   int          corrupt_idx = -1;
   int          wleft = 0;
   int          rd_idx = 0;
   int          low_run = 0;
   int          gap_cnt = 0;
   int          stb_cyc = 0;
   bit          waiting = 1'b0;
   logic [33:0] snap_ctl;
   logic [31:0] snap_dat;
   beat_t       beat_log[$];
   logic [31:0] mem [logic [AW-1:0]];

   always @(negedge clk) begin
      if (!rst_n) begin
         ack = 1'b0;
         waiting = 1'b0;
         low_run = 0;
      end else begin
         if (waiting && stb) begin
            check("stable_ctl", 64'({addr, we, cti, sel}), 64'(snap_ctl));
            check("stable_dat", 64'(dat_o), 64'(snap_dat));
         end
         waiting = 1'b0;
         if (ack) begin
            ack = 1'b0;
            wleft = $urandom_range(max_wait, 0);
         end
         if (stb) begin
            stb_cyc++;
            if (low_run != 0) begin
               check("gap_len", 64'(low_run), 64'd1);
               gap_cnt++;
            end
            low_run = 0;
            if (!no_ack && wleft == 0) begin
               logic [31:0] rdat;
               ack = 1'b1;
               check("sel_cyc", 64'({sel, cyc}), 64'h1F);
               beat_log.push_back('{addr: addr, we: we, dat: dat_o, cti: cti});
               if (we) begin
                  mem[addr] = dat_o;
               end else begin
                  rdat = mem.exists(addr) ? mem[addr] : 32'h0;
                  if (rd_idx == corrupt_idx) rdat = rdat ^ 32'h1;
                  dat_i = rdat;
                  rd_idx++;
               end
            end else begin
               if (wleft > 0) wleft--;
               waiting = 1'b1;
               snap_ctl = {addr, we, cti, sel};
               snap_dat = dat_o;
            end
         end else begin
            if (busy) low_run++;
            if (spur && $urandom_range(1, 0) == 1) ack = 1'b1;
         end
      end
   end

   task automatic start_test(input logic [AW-1:0] base, input int len, input int nb,
                             input int maxw, input int corrupt, input bit sp, input bit na);
      cfg_base = base;
      cfg_len  = 5'(len);
      cfg_nb   = 8'(nb);
      max_wait = maxw;
      corrupt_idx = corrupt;
      spur     = sp;
      no_ack   = na;
      beat_log.delete();
      mem.delete();
      rd_idx = 0; gap_cnt = 0; stb_cyc = 0; low_run = 0;
      wleft = $urandom_range(maxw, 0);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic check_result(input string name, input logic [AW-1:0] base, input int len,
                               input int nb, input int corrupt);
      int le, nbe, n, idx, exp_err;
      logic [AW-1:0] b, ea;
      logic [2:0] ec;
      le  = (len == 0) ? 1 : len;
      nbe = (nb == 0) ? 1 : nb;
      n   = le * nbe;
      b   = base & ~AW'(3);
      check({name, ".n_beats"}, 64'(beat_log.size()), 64'(2 * n));
      for (int i = 0; i < beat_log.size() && i < 2 * n; i++) begin
         idx = i % n;
         ea  = b + AW'(4 * idx);
         ec  = ((idx % le) == le - 1) ? 3'b111 : 3'b010;
         check($sformatf("%s.addr[%0d]", name, i), 64'(beat_log[i].addr), 64'(ea));
         check($sformatf("%s.we[%0d]", name, i), 64'(beat_log[i].we), 64'(i < n));
         check($sformatf("%s.cti[%0d]", name, i), 64'(beat_log[i].cti), 64'(ec));
         if (i < n)
            check($sformatf("%s.wdat[%0d]", name, i), 64'(beat_log[i].dat), 64'(exp_lfsr[idx]));
      end
      exp_err = (corrupt >= 0 && corrupt < n) ? 1 : 0;
      check({name, ".gaps"}, 64'(gap_cnt), 64'(2 * nbe - 1));
      check({name, ".err_count"}, 64'(err_count), 64'(exp_err));
      check({name, ".first_err"}, 64'(first_err_addr),
            exp_err != 0 ? 64'(AW'(b + AW'(4 * corrupt))) : 64'd0);
      check({name, ".status"}, 64'({done, busy, timeout, pass, stb, cyc}),
            64'({1'b1, 1'b0, 1'b0, exp_err == 0, 1'b0, 1'b0}));
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, ".ctl"}, 64'({busy, done, pass, timeout, cyc, stb, we, sel, cti}), 64'd0);
      check({name, ".addr_err"}, 64'({addr, first_err_addr, err_count}), 64'd0);
      check({name, ".dat"}, 64'(dat_o), 64'd0);
   endtask

   initial begin
      bit ok;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;

      // Standalone LFSR against the arithmetic reference.
      @(negedge clk) rl_load = 1'b1;
      @(negedge clk) rl_load = 1'b0;
      check("lfsr_load", 64'(rl_q), 64'(SEED));
      rl_adv = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("lfsr_step%0d", k), 64'(rl_q), 64'(exp_lfsr[k]));
      end
      rl_adv = 1'b0;

      // 1: zero-wait responder
      start_test(26'h100, 4, 2, 0, -1, 1'b0, 1'b0);
      wait_done(2000, ok); check("t1.done_seen", 64'(ok), 64'd1);
      check_result("t1", 26'h100, 4, 2, -1);

      // 2: random wait states, single-beat bursts, stray acks during gaps
      start_test(26'h2000, 1, 3, 5, -1, 1'b1, 1'b0);
      wait_done(2000, ok); check("t2.done_seen", 64'(ok), 64'd1);
      check_result("t2", 26'h2000, 1, 3, -1);

      // 3: corrupted read beat 5
      start_test(26'h0, 4, 2, 2, 5, 1'b0, 1'b0);
      wait_done(2000, ok); check("t3.done_seen", 64'(ok), 64'd1);
      check_result("t3", 26'h0, 4, 2, 5);

      // 4: responder never acks
      start_test(26'h100, 4, 2, 0, -1, 1'b0, 1'b1);
      wait_done(3000, ok); check("t4.done_seen", 64'(ok), 64'd1);
      check("t4.stb_cycles", 64'(stb_cyc), 64'd1023);
      check("t4.n_beats", 64'(beat_log.size()), 64'd0);
      check("t4.status", 64'({done, busy, timeout, pass, stb, cyc}), 64'b101000);
      no_ack = 1'b0;

      // 5: asynchronous reset mid write burst, then clean rerun
      start_test(26'h200, 8, 2, 0, -1, 1'b0, 1'b0);
      for (int i = 0; i < 200 && beat_log.size() < 3; i++) @(negedge clk);
      check("t5.mid_burst", 64'({busy, stb}), 64'b11);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("t5.rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      start_test(26'h200, 8, 2, 0, -1, 1'b0, 1'b0);
      wait_done(2000, ok); check("t5.done_seen", 64'(ok), 64'd1);
      check_result("t5", 26'h200, 8, 2, -1);

      // 6: address wrap, ignored start while busy, len 0 as 1
      start_test(26'h3FFFFF8, 4, 2, 1, -1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      cfg_base = 26'h40; cfg_len = 5'd2; cfg_nb = 8'd5;
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(2000, ok); check("t6.done_seen", 64'(ok), 64'd1);
      check_result("t6", 26'h3FFFFF8, 4, 2, -1);
      start_test(26'h80, 0, 3, 1, -1, 1'b0, 1'b0);
      wait_done(2000, ok); check("t6b.done_seen", 64'(ok), 64'd1);
      check_result("t6b", 26'h80, 0, 3, -1);

      // Randomized configurations
      for (int r = 0; r < 4; r++) begin
         logic [AW-1:0] rb;
         int rl, rn, rw, rc, ne;
         rb = AW'($urandom);
         rl = $urandom_range(31, 0);
         rn = $urandom_range(3, 0);
         rw = $urandom_range(3, 0);
         ne = ((rl == 0) ? 1 : rl) * ((rn == 0) ? 1 : rn);
         rc = ($urandom_range(1, 0) == 1) ? $urandom_range(ne - 1, 0) : -1;
         start_test(rb, rl, rn, rw, rc, 1'b1, 1'b0);
         wait_done(4000, ok); check($sformatf("rnd%0d.done_seen", r), 64'(ok), 64'd1);
         check_result($sformatf("rnd%0d", r), rb, rl, rn, rc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
